// File: rtl/ysyx_23060025_axi_rd_sram_pkg.sv
// Shared types and AXI encodings for the SRAM-backed AXI4 read responder.
package ysyx_23060025_axi_rd_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  localparam logic [1:0] AXI_ADDR_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_ADDR_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_ADDR_BURST_WRAP  = 2'b10;
  localparam logic [1:0] AXI_ADDR_BURST_RSVD  = 2'b11;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/ysyx_23060025_axi_burst_addr.sv
// Combinational AXI burst address stepper: next beat address plus a burst legality flag.
module ysyx_23060025_axi_burst_addr
  import ysyx_23060025_axi_rd_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_legal
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_span_mask;
  logic [ADDR_WIDTH-1:0] w_incr;

  assign w_step      = ADDR_WIDTH'(1) << i_size;
  assign w_span_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
  assign w_incr      = i_addr + w_step;

  always_comb begin
    o_next_addr = w_incr;
    case (i_burst)
      AXI_ADDR_BURST_FIXED: o_next_addr = i_addr;
      AXI_ADDR_BURST_WRAP:  o_next_addr = (i_addr & ~w_span_mask) | (w_incr & w_span_mask);
      default:              o_next_addr = w_incr;
    endcase
  end

  assign o_legal = (i_size <= 3'd2) && (i_burst != AXI_ADDR_BURST_RSVD) &&
                   ((i_burst != AXI_ADDR_BURST_WRAP) || wrap_len_ok(i_len));

endmodule

// File: rtl/ysyx_23060025_axi_rd_sram.sv
// AXI4 read-only responder in front of a word-addressed SRAM with a preload write port.
module ysyx_23060025_axi_rd_sram
  import ysyx_23060025_axi_rd_sram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] in_araddr,
  input  logic                  in_arvalid,
  output logic                  in_arready,
  input  logic [7:0]            in_arlen,
  input  logic [2:0]            in_arsize,
  input  logic [1:0]            in_arburst,
  output logic                  in_rvalid,
  input  logic                  in_rready,
  output logic [DATA_WIDTH-1:0] in_rdata,
  output logic [1:0]            in_rresp,
  output logic                  in_rlast,
  input  logic                  pl_wen,
  input  logic [MEM_AW-1:0]     pl_waddr,
  input  logic [DATA_WIDTH-1:0] pl_wdata
);

  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4) << MEM_AW;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            r_lat_cnt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_legal;
  logic [ADDR_WIDTH-1:0] w_fetch_addr;
  logic [ADDR_WIDTH-1:0] w_fetch_off;
  logic                  w_fetch_ok;
  logic [DATA_WIDTH-1:0] w_fetch_data;

  ysyx_23060025_axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_burst_addr (
    .i_addr      (r_addr),
    .i_size      (r_size),
    .i_len       (r_len),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr),
    .o_legal     (w_legal)
  );

  // In WAIT the first beat comes from the latched address; in BEAT we prefetch the next one.
  assign w_fetch_addr = (r_state == ST_BEAT) ? w_next_addr : r_addr;
  assign w_fetch_off  = w_fetch_addr - BASE_ADDR;
  assign w_fetch_ok   = w_legal && (w_fetch_addr >= BASE_ADDR) &&
                        ({1'b0, w_fetch_off} < MEM_BYTES);
  assign w_fetch_data = r_mem[w_fetch_off[MEM_AW+1:2]];

  // Preload port is independent of the FSM; a same-cycle beat fetch sees the old word.
  always_ff @(posedge clock) begin
    if (pl_wen) r_mem[pl_waddr] <= pl_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_lat_cnt  <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rresp    <= AXI_RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_arready <= 1'b1;
          if (r_arready && in_arvalid) begin
            r_addr     <= in_araddr;
            r_len      <= in_arlen;
            r_size     <= in_arsize;
            r_burst    <= in_arburst;
            r_beat_cnt <= '0;
            r_lat_cnt  <= 8'(LATENCY - 1);
            r_arready  <= 1'b0;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == 8'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_fetch_ok ? w_fetch_data : '0;
            r_rresp  <= w_fetch_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            r_rlast  <= (r_len == 8'd0);
            r_state  <= ST_BEAT;
          end else begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
          end
        end
        ST_BEAT: begin
          if (in_rready) begin
            if (r_beat_cnt == r_len) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
              r_addr     <= w_next_addr;
              r_rdata    <= w_fetch_ok ? w_fetch_data : '0;
              r_rresp    <= w_fetch_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
              r_rlast    <= ((r_beat_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_arready = r_arready;
  assign in_rvalid  = r_rvalid;
  assign in_rlast   = r_rlast;
  assign in_rresp   = r_rresp;
  assign in_rdata   = r_rdata;

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_sram.sv
// Randomized bench for the AXI read SRAM responder against a burst-level reference model.
module tb_ysyx_23060025_axi_rd_sram;

  localparam int          LAT    = 4;
  localparam int          MEM_AW = 12;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] TOP    = BASE + 32'd16384;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_araddr = '0;
  logic        in_arvalid = 1'b0;
  logic        in_arready;
  logic [7:0]  in_arlen = '0;
  logic [2:0]  in_arsize = '0;
  logic [1:0]  in_arburst = '0;
  logic        in_rvalid;
  logic        in_rready = 1'b0;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic        in_rlast;
  logic        pl_wen = 1'b0;
  logic [11:0] pl_waddr = '0;
  logic [31:0] pl_wdata = '0;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_mem [4096];

  always #5 clock = ~clock;

  ysyx_23060025_axi_rd_sram #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_AW     (MEM_AW),
    .BASE_ADDR  (BASE),
    .LATENCY    (LAT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_araddr  (in_araddr),
    .in_arvalid (in_arvalid),
    .in_arready (in_arready),
    .in_arlen   (in_arlen),
    .in_arsize  (in_arsize),
    .in_arburst (in_arburst),
    .in_rvalid  (in_rvalid),
    .in_rready  (in_rready),
    .in_rdata   (in_rdata),
    .in_rresp   (in_rresp),
    .in_rlast   (in_rlast),
    .pl_wen     (pl_wen),
    .pl_waddr   (pl_waddr),
    .pl_wdata   (pl_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address of beat i, computed directly from the burst start rather than step by step.
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    logic [31:0] step, span, wbase;
    step = 32'd1 << size;
    if (burst == 0) return start;
    if (burst == 2) begin
      span  = 32'(len + 1) * step;
      wbase = start - (start % span);
      return wbase + ((start - wbase + 32'(i) * step) % span);
    end
    return start + 32'(i) * step;
  endfunction

  function automatic bit beat_err(input logic [31:0] a, input int len, input int size, input int burst);
    bit wrap_bad;
    wrap_bad = (burst == 2) && !(len == 1 || len == 3 || len == 7 || len == 15);
    return (size > 2) || (burst == 3) || wrap_bad || (a < BASE) || (a >= TOP);
  endfunction

  task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                           input int burst, input int bp_pct, input bit collide);
    logic [31:0] exp_d[$];
    logic [1:0]  exp_r[$];
    logic [31:0] a, off, held_d, new_word;
    logic [1:0]  held_r;
    logic        held_l;
    int n, beat;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, size, burst, i);
      off = a - BASE;
      if (beat_err(a, len, size, burst)) begin
        exp_d.push_back(32'h0);
        exp_r.push_back(2'b10);
      end else begin
        exp_d.push_back(model_mem[off[13:2]]);
        exp_r.push_back(2'b00);
      end
    end
    off = addr - BASE;
    new_word = $urandom;

    in_araddr = addr; in_arlen = 8'(len); in_arsize = 3'(size); in_arburst = 2'(burst);
    in_arvalid = 1'b1;
    n = 0;
    while (!in_arready && n < 50) begin @(posedge clock); #1; n++; end
    if (!in_arready) begin
      chk("ar_timeout", 32'(in_arready), 32'd1);
      in_arvalid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    in_arvalid = 1'b0;

    n = 0;
    while (!in_rvalid && n < 300) begin
      chk("arready_wait", 32'(in_arready), 32'd0);
      if (collide && n == LAT - 1) begin
        pl_wen = 1'b1; pl_waddr = off[13:2]; pl_wdata = new_word;
      end
      @(posedge clock); #1;
      pl_wen = 1'b0;
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    if (collide) model_mem[off[13:2]] = new_word;

    beat = 0; n = 0;
    while (beat <= len && n < 2000) begin
      if ($urandom_range(99) < 32'(bp_pct)) begin
        in_rready = 1'b0;
        held_d = in_rdata; held_r = in_rresp; held_l = in_rlast;
        @(posedge clock); #1;
        chk("hold_rvalid", 32'(in_rvalid), 32'd1);
        chk("hold_rdata", in_rdata, held_d);
        chk("hold_rresp", 32'(in_rresp), 32'(held_r));
        chk("hold_rlast", 32'(in_rlast), 32'(held_l));
        chk("arready_stall", 32'(in_arready), 32'd0);
      end else begin
        in_rready = 1'b1;
        chk("rvalid", 32'(in_rvalid), 32'd1);
        chk("rdata", in_rdata, exp_d[beat]);
        chk("rresp", 32'(in_rresp), 32'(exp_r[beat]));
        chk("rlast", 32'(in_rlast), 32'(beat == len));
        chk("arready_beat", 32'(in_arready), 32'd0);
        @(posedge clock); #1;
        beat++;
      end
      n++;
    end
    in_rready = 1'b0;
    if (beat <= len) chk("beat_timeout", 32'(beat), 32'(len + 1));
    chk("rvalid_end", 32'(in_rvalid), 32'd0);
    chk("rlast_end", 32'(in_rlast), 32'd0);
    chk("arready_end", 32'(in_arready), 32'd1);
  endtask

  initial begin
    int n;
    int lens[7];
    logic [31:0] a;
    lens = '{0, 1, 2, 3, 7, 15, 5};

    // reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rvalid", 32'(in_rvalid), 32'd0);
    chk("rst_rlast", 32'(in_rlast), 32'd0);
    chk("rst_rresp", 32'(in_rresp), 32'd0);
    chk("rst_rdata", in_rdata, 32'd0);
    chk("rst_arready", 32'(in_arready), 32'd0);
    reset = 1'b0;
    #1;
    chk("arready_pre", 32'(in_arready), 32'd0);
    @(posedge clock); #1;
    chk("arready_rise", 32'(in_arready), 32'd1);

    // preload every word so any in-range address has a known value
    for (int i = 0; i < 4096; i++) begin
      model_mem[i] = (i < 16) ? 32'h1000_0000 + 32'(i) : $urandom;
      pl_wen = 1'b1; pl_waddr = 12'(i); pl_wdata = model_mem[i];
      @(posedge clock); #1;
    end
    pl_wen = 1'b0;

    run_burst(32'h8000_0000, 3, 2, 1, 0, 1'b0);
    run_burst(32'h8000_0008, 3, 2, 2, 0, 1'b0);
    run_burst(32'h8000_0000, 7, 2, 1, 50, 1'b0);
    run_burst(32'h7FFF_FFFC, 0, 2, 1, 0, 1'b0);
    run_burst(32'h8000_0000, 2, 2, 2, 0, 1'b0);
    run_burst(32'h8000_0000, 0, 3, 1, 0, 1'b0);
    run_burst(32'h8000_0004, 1, 2, 3, 0, 1'b0);
    run_burst(TOP - 32'd8, 3, 2, 1, 20, 1'b0);
    run_burst(32'h8000_0043, 5, 0, 1, 30, 1'b0);
    run_burst(32'h8000_0012, 3, 1, 0, 30, 1'b0);
    run_burst(32'h8000_0006, 7, 1, 2, 30, 1'b0);
    run_burst(32'h8000_0050, 0, 2, 1, 0, 1'b1);
    run_burst(32'h8000_0050, 0, 2, 1, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(9) < 8) a = BASE + $urandom_range(0, 16383);
      else a = $urandom;
      run_burst(a, lens[$urandom_range(0, 6)], $urandom_range(0, 3),
                $urandom_range(0, 3), 40, 1'b0);
    end

    // reset while beat 2 of an 8-beat burst is on the bus
    in_araddr = BASE; in_arlen = 8'd7; in_arsize = 3'd2; in_arburst = 2'b01;
    in_arvalid = 1'b1;
    n = 0;
    while (!in_arready && n < 50) begin @(posedge clock); #1; n++; end
    @(posedge clock); #1;
    in_arvalid = 1'b0;
    n = 0;
    while (!in_rvalid && n < 300) begin @(posedge clock); #1; n++; end
    chk("mid_rvalid_up", 32'(in_rvalid), 32'd1);
    in_rready = 1'b1;
    @(posedge clock); #1;
    chk("mid_beat2", in_rdata, 32'h1000_0001);
    reset = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(in_rvalid), 32'd0);
    chk("mid_rst_rlast", 32'(in_rlast), 32'd0);
    chk("mid_rst_rdata", in_rdata, 32'd0);
    chk("mid_rst_arready", 32'(in_arready), 32'd0);
    @(posedge clock); #1;
    in_rready = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_rst_rvalid", 32'(in_rvalid), 32'd0);
    end
    run_burst(32'h8000_0014, 0, 2, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
